// File: rtl/lcd_timing_gen.sv
// Parametrised LCD panel timing generator: pixel-tick divider, H/V raster counters,
// registered HD/VD/DEN with active coordinates, line/frame strobes and a look-ahead fetch request.
`default_nettype none

module lcd_timing_gen #(
  parameter int unsigned H_ACTIVE  = 800,
  parameter int unsigned H_FP      = 40,
  parameter int unsigned H_SYNC    = 1,
  parameter int unsigned H_BP      = 215,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 1,
  parameter int unsigned V_BP      = 34,
  parameter int unsigned CLK_DIV   = 1,
  parameter bit          SYNC_POL  = 1'b0,
  parameter int unsigned LOOKAHEAD = 2,
  parameter int unsigned XW        = 11,
  parameter int unsigned YW        = 10,
  parameter int unsigned FW        = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  output logic          PIX_TICK,
  output logic          HD,
  output logic          VD,
  output logic          DEN,
  output logic [XW-1:0] Columna,
  output logic [YW-1:0] Fila,
  output logic          LINE_START,
  output logic          FRAME_START,
  output logic [FW-1:0] FRAME_CNT,
  output logic          REQ,
  output logic [XW-1:0] REQ_X,
  output logic [YW-1:0] REQ_Y
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned H_START = H_SYNC + H_BP;
  localparam int unsigned V_START = V_SYNC + V_BP;
  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam longint unsigned X_SPAN = 64'd1 << XW;
  localparam longint unsigned Y_SPAN = 64'd1 << YW;

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [XW-1:0] H_LAST     = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST     = YW'(V_TOTAL - 1);
  // Decode compares run one bit wider so H_START+H_ACTIVE == 2^XW cannot alias to 0.
  localparam logic [XW:0]   H_SYNC_END = (XW+1)'(H_SYNC);
  localparam logic [XW:0]   H_BEG      = (XW+1)'(H_START);
  localparam logic [XW:0]   H_END      = (XW+1)'(H_START + H_ACTIVE);
  localparam logic [XW:0]   LA         = (XW+1)'(LOOKAHEAD);
  localparam logic [YW:0]   V_SYNC_END = (YW+1)'(V_SYNC);
  localparam logic [YW:0]   V_BEG      = (YW+1)'(V_START);
  localparam logic [YW:0]   V_END      = (YW+1)'(V_START + V_ACTIVE);

  generate
    if (LOOKAHEAD >= H_START || 64'(H_TOTAL) > X_SPAN || 64'(V_TOTAL) > Y_SPAN ||
        H_SYNC == 0 || H_ACTIVE == 0 || V_SYNC == 0 || V_ACTIVE == 0 || CLK_DIV == 0)
    begin : g_bad_params
      $error("lcd_timing_gen: illegal timing parameter set");
    end
  endgenerate

  typedef struct packed {
    logic          hd;
    logic          vd;
    logic          den;
    logic [XW-1:0] col;
    logic [YW-1:0] row;
    logic          line_start;
    logic          frame_start;
    logic          req;
    logic [XW-1:0] req_x;
    logic [YW-1:0] req_y;
  } pins_t;

  localparam pins_t PINS_PARK = '{hd: ~SYNC_POL, vd: ~SYNC_POL, default: '0};

  logic          run_q, run_d;
  logic [DW-1:0] div_q, div_d;
  logic [XW-1:0] h_q, h_d;
  logic [YW-1:0] v_q, v_d;
  pins_t         pins_q, pins_d, pins_next;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          tick;

  // run_q holds off the first tick for one cycle after reset or re-enable, which keeps
  // PIX_TICK low throughout reset without routing the async reset into datapath logic.
  assign tick     = EN && run_q && (div_q == DIV_LAST);
  assign PIX_TICK = tick;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    run_d = EN;
    div_d = '0;
    h_d   = H_LAST;
    v_d   = V_LAST;
    if (EN) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
      h_d   = h_q;
      v_d   = v_q;
      if (tick) begin
        h_d = (h_q == H_LAST) ? '0 : h_q + XW'(1);
        if (h_q == H_LAST) begin
          v_d = (v_q == V_LAST) ? '0 : v_q + YW'(1);
        end
      end
    end
  end

  // Pins describe the position the counters will hold after this edge (zero latency).
  logic [XW:0] h_x, h_la;
  logic [YW:0] v_x;
  logic        h_act, v_act, r_act;

  always_comb begin
    h_x   = {1'b0, h_d};
    v_x   = {1'b0, v_d};
    h_la  = h_x + LA;
    h_act = (h_x >= H_BEG) && (h_x < H_END);
    v_act = (v_x >= V_BEG) && (v_x < V_END);
    r_act = (h_la >= H_BEG) && (h_la < H_END) && v_act;

    pins_next             = PINS_PARK;
    pins_next.hd          = (h_x < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    pins_next.vd          = (v_x < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
    pins_next.den         = h_act && v_act;
    pins_next.line_start  = (h_d == '0);
    pins_next.frame_start = (h_d == '0) && (v_d == '0);
    if (h_act && v_act) begin
      pins_next.col = XW'(h_x - H_BEG);
      pins_next.row = YW'(v_x - V_BEG);
    end
    if (r_act) begin
      pins_next.req   = 1'b1;
      pins_next.req_x = XW'(h_la - H_BEG);
      pins_next.req_y = YW'(v_x - V_BEG);
    end
  end

  always_comb begin
    pins_d = pins_q;
    fcnt_d = fcnt_q;
    if (!EN) begin
      pins_d = PINS_PARK;
    end else if (tick) begin
      pins_d = pins_next;
      if (pins_next.frame_start) begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      run_q  <= 1'b0;
      div_q  <= '0;
      h_q    <= H_LAST;
      v_q    <= V_LAST;
      pins_q <= PINS_PARK;
      fcnt_q <= '0;
    end else begin
      run_q  <= run_d;
      div_q  <= div_d;
      h_q    <= h_d;
      v_q    <= v_d;
      pins_q <= pins_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign HD          = pins_q.hd;
  assign VD          = pins_q.vd;
  assign DEN         = pins_q.den;
  assign Columna     = pins_q.col;
  assign Fila        = pins_q.row;
  assign LINE_START  = pins_q.line_start;
  assign FRAME_START = pins_q.frame_start;
  assign FRAME_CNT   = fcnt_q;
  assign REQ         = pins_q.req;
  assign REQ_X       = pins_q.req_x;
  assign REQ_Y       = pins_q.req_y;

endmodule

`default_nettype wire

// File: tb/tb_lcd_timing_gen.sv
// Scoreboard bench: two small-raster instances (divided clock with look-ahead, and
// active-high sync with REQ==DEN) plus one default-timing instance for the 1056x525 raster.
`timescale 1ns/1ps

module tb_lcd_timing_gen;

  typedef struct packed {
    logic        hd;
    logic        vd;
    logic        den;
    logic [10:0] col;
    logic [9:0]  row;
    logic        ls;
    logic        fs;
    logic [7:0]  fcnt;
    logic        req;
    logic [10:0] reqx;
    logic [9:0]  reqy;
  } out_t;

  // Hand-derived raster of the small timing: H_TOTAL=8 (sync 0-1, bp 2, active 3-6, fp 7),
  // V_TOTAL=5 (sync 0, bp 1, active 2-3, fp 4), 40 ticks per frame.
  localparam int HS_T   [8] = '{1, 1, 0, 0, 0, 0, 0, 0};
  localparam int HDEN_T [8] = '{0, 0, 0, 1, 1, 1, 1, 0};
  localparam int COL_T  [8] = '{0, 0, 0, 0, 1, 2, 3, 0};
  localparam int HREQ_T [8] = '{0, 1, 1, 1, 1, 0, 0, 0};
  localparam int REQX_T [8] = '{0, 0, 1, 2, 3, 0, 0, 0};
  localparam int VACT_T [5] = '{0, 0, 1, 1, 0};
  localparam int ROW_T  [5] = '{0, 0, 0, 1, 0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, rst_c, c_done;
  int   checks = 0;
  int   errors = 0;
  out_t qa[$];
  out_t qb[$];

  logic a_pix, a_hd, a_vd, a_den, a_ls, a_fs, a_req;
  logic [10:0] a_col, a_rx;
  logic [9:0]  a_row, a_ry;
  logic [7:0]  a_fcnt;
  logic b_pix, b_hd, b_vd, b_den, b_ls, b_fs, b_req;
  logic [10:0] b_col, b_rx;
  logic [9:0]  b_row, b_ry;
  logic [7:0]  b_fcnt;
  logic c_pix, c_hd, c_vd, c_den, c_ls, c_fs, c_req;
  logic [10:0] c_col, c_rx;
  logic [9:0]  c_row, c_ry;
  logic [7:0]  c_fcnt;

  out_t act_a, act_b;
  assign act_a = {a_hd, a_vd, a_den, a_col, a_row, a_ls, a_fs, a_fcnt, a_req, a_rx, a_ry};
  assign act_b = {b_hd, b_vd, b_den, b_col, b_row, b_ls, b_fs, b_fcnt, b_req, b_rx, b_ry};

  lcd_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(3), .SYNC_POL(1'b0), .LOOKAHEAD(2)
  ) dut_a (
    .CLK(clk), .RST(rst), .EN(en), .PIX_TICK(a_pix), .HD(a_hd), .VD(a_vd), .DEN(a_den),
    .Columna(a_col), .Fila(a_row), .LINE_START(a_ls), .FRAME_START(a_fs),
    .FRAME_CNT(a_fcnt), .REQ(a_req), .REQ_X(a_rx), .REQ_Y(a_ry)
  );

  lcd_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .SYNC_POL(1'b1), .LOOKAHEAD(0)
  ) dut_b (
    .CLK(clk), .RST(rst), .EN(en), .PIX_TICK(b_pix), .HD(b_hd), .VD(b_vd), .DEN(b_den),
    .Columna(b_col), .Fila(b_row), .LINE_START(b_ls), .FRAME_START(b_fs),
    .FRAME_CNT(b_fcnt), .REQ(b_req), .REQ_X(b_rx), .REQ_Y(b_ry)
  );

  lcd_timing_gen dut_c (
    .CLK(clk), .RST(rst_c), .EN(1'b1), .PIX_TICK(c_pix), .HD(c_hd), .VD(c_vd), .DEN(c_den),
    .Columna(c_col), .Fila(c_row), .LINE_START(c_ls), .FRAME_START(c_fs),
    .FRAME_CNT(c_fcnt), .REQ(c_req), .REQ_X(c_rx), .REQ_Y(c_ry)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected pins for the pos-th tick after a frame start.
  function automatic out_t exp_at(input int pos, input bit pol, input bit la, input int base);
    out_t e;
    int   h, v;
    bit   den, req;
    h   = pos % 8;
    v   = (pos / 8) % 5;
    den = (HDEN_T[h] != 0) && (VACT_T[v] != 0);
    req = la ? ((HREQ_T[h] != 0) && (VACT_T[v] != 0)) : den;
    e      = '0;
    e.hd   = (HS_T[h] != 0) ? pol : ~pol;
    e.vd   = (v == 0) ? pol : ~pol;
    e.den  = den;
    e.col  = den ? 11'(COL_T[h]) : 11'd0;
    e.row  = den ? 10'(ROW_T[v]) : 10'd0;
    e.ls   = (h == 0);
    e.fs   = (h == 0) && (v == 0);
    e.fcnt = 8'(base + pos / 40 + 1);
    e.req  = req;
    e.reqx = req ? 11'(la ? REQX_T[h] : COL_T[h]) : 11'd0;
    e.reqy = req ? 10'(ROW_T[v]) : 10'd0;
    return e;
  endfunction

  function automatic out_t parked(input bit pol, input int fcnt);
    out_t e;
    e      = '0;
    e.hd   = ~pol;
    e.vd   = ~pol;
    e.fcnt = 8'(fcnt);
    return e;
  endfunction

  task automatic push_run(input int n_a, input int base_a, input int n_b, input int base_b);
    for (int i = 0; i < n_a; i++) qa.push_back(exp_at(i, 1'b0, 1'b1, base_a));
    for (int i = 0; i < n_b; i++) qb.push_back(exp_at(i, 1'b1, 1'b0, base_b));
  endtask

  task automatic check_parked(input string tag, input int fa, input int fb);
    check({tag, " A pins"}, 64'(act_a), 64'(parked(1'b0, fa)));
    check({tag, " B pins"}, 64'(act_b), 64'(parked(1'b1, fb)));
    check({tag, " A PIX_TICK"}, 64'(a_pix), 64'd0);
    check({tag, " B PIX_TICK"}, 64'(b_pix), 64'd0);
  endtask

  // Monitors: a PIX_TICK seen at one falling edge means the next rising edge updates the pins.
  initial begin : mon_a
    bit prev;
    int n;
    prev = 1'b0;
    n    = 0;
    forever begin
      @(negedge clk);
      if (rst) prev = 1'b0;
      else begin
        if (prev) begin
          check($sformatf("A expectation queued for tick %0d", n), 64'(qa.size() != 0), 64'd1);
          if (qa.size() != 0) check($sformatf("A tick %0d pins", n), 64'(act_a), 64'(qa.pop_front()));
          n++;
        end
        prev = a_pix;
      end
    end
  end

  initial begin : mon_b
    bit prev;
    int n;
    prev = 1'b0;
    n    = 0;
    forever begin
      @(negedge clk);
      if (rst) prev = 1'b0;
      else begin
        if (prev) begin
          check($sformatf("B expectation queued for tick %0d", n), 64'(qb.size() != 0), 64'd1);
          if (qb.size() != 0) check($sformatf("B tick %0d pins", n), 64'(act_b), 64'(qb.pop_front()));
          n++;
        end
        prev = b_pix;
      end
    end
  end

  // Default 1056x525 raster: locate the first REQ and DEN and count sync ticks up to it.
  initial begin : c_run
    bit prev, found;
    int pos, hd_n, vd_n, req_pos, req_x, den_pos, den_col, den_row, den_fcnt;
    prev = 1'b0; found = 1'b0; pos = -1; hd_n = 0; vd_n = 0;
    req_pos = -1; req_x = -1; den_pos = -1; den_col = -1; den_row = -1; den_fcnt = -1;
    c_done = 1'b0;
    rst_c  = 1'b0;
    #1 rst_c = 1'b1;
    #2;
    check("C reset HD", 64'(c_hd), 64'd1);
    check("C reset DEN", 64'(c_den), 64'd0);
    check("C reset PIX_TICK", 64'(c_pix), 64'd0);
    @(posedge clk);
    #1 rst_c = 1'b0;
    for (int cyc = 0; cyc < 40000 && !found; cyc++) begin
      @(negedge clk);
      if (prev) begin
        pos++;
        if (!c_hd) hd_n++;
        if (!c_vd) vd_n++;
        if (c_req && req_pos < 0) begin
          req_pos = pos;
          req_x   = int'(c_rx);
        end
        if (c_den) begin
          found    = 1'b1;
          den_pos  = pos;
          den_col  = int'(c_col);
          den_row  = int'(c_row);
          den_fcnt = int'(c_fcnt);
        end
      end
      prev = c_pix;
    end
    check("C first DEN tick (v=35,h=216)", 64'(den_pos), 64'd37176);
    check("C first DEN Columna", 64'(den_col), 64'd0);
    check("C first DEN Fila", 64'(den_row), 64'd0);
    check("C FRAME_CNT in frame 1", 64'(den_fcnt), 64'd1);
    check("C HD active ticks over 36 line starts", 64'(hd_n), 64'd36);
    check("C VD active ticks in line 0", 64'(vd_n), 64'd1056);
    check("C first REQ tick", 64'(req_pos), 64'd37174);
    check("C first REQ_X", 64'(req_x), 64'd0);
    c_done = 1'b1;
  end

  initial begin : stim
    rst = 1'b0;
    en  = 1'b1;
    #1 rst = 1'b1;
    #2;
    check_parked("reset", 0, 0);
    repeat (2) @(posedge clk);
    #1;
    // 303 edges: A ticks every 3rd edge (101), B every edge after the first (302).
    push_run(101, 0, 302, 0);
    rst = 1'b0;
    repeat (303) @(posedge clk);
    #1 en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check_parked("EN drop mid-line", 3, 8);
    repeat (9) @(posedge clk);
    #1;
    check_parked("EN held low", 3, 8);
    push_run(20, 3, 59, 8);
    en = 1'b1;
    repeat (60) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check_parked("async reset mid-line", 0, 0);
    repeat (2) @(posedge clk);
    #1;
    push_run(45, 0, 134, 0);
    rst = 1'b0;
    repeat (135) @(posedge clk);
    #1 en = 1'b0;
    repeat (4) @(posedge clk);
    check("A scoreboard drained", 64'(qa.size()), 64'd0);
    check("B scoreboard drained", 64'(qb.size()), 64'd0);
    wait (c_done);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
